// File: rtl/chunked_seq_adder.sv
// Multi-cycle WIDTH-bit adder that reuses one CHUNK-bit slice per clock, with valid/ready on both sides.
// Define ADDER_SUB_EN to add a 'sub' input that computes a - b - cin (cout is then the inverted borrow).
module chunked_seq_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = (CHUNK > 0) ? WIDTH / CHUNK : 1;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if (CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_chunk_range
            $error("chunked_seq_adder: CHUNK must satisfy 1 <= CHUNK <= WIDTH");
        end else if (WIDTH % CHUNK != 0) begin : g_bad_chunk_multiple
            $error("chunked_seq_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   b_eff;
    logic               cin_eff;
    logic               accept;
    logic               last_slice;
    logic [CHUNK:0]     slice_res;
    logic [CHUNK-1:0]   slice_sum;
    logic               slice_carry;
    logic               msb_carry_in;

    function automatic logic [CHUNK:0] add_slice(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             ci);
        add_slice = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
    endfunction

    // Subtraction is folded into the operands at accept time: a + ~b + ~cin.
`ifdef ADDER_SUB_EN
    assign b_eff   = sub ? ~b   : b;
    assign cin_eff = sub ? ~cin : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == HOLD);
    assign accept     = (state == IDLE) && in_valid;
    assign last_slice = (cnt == CNT_W'(NCHUNK - 1));

    // Operands shift right one slice per RUN cycle, so the active slice is always the low CHUNK bits.
    assign slice_res    = add_slice(opa[CHUNK-1:0], opb[CHUNK-1:0], carry);
    assign slice_sum    = slice_res[CHUNK-1:0];
    assign slice_carry  = slice_res[CHUNK];
    assign msb_carry_in = opa[CHUNK-1] ^ opb[CHUNK-1] ^ slice_sum[CHUNK-1];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid)   state_nxt = RUN;
            RUN:  if (last_slice) state_nxt = HOLD;
            HOLD: if (out_ready)  state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            opa <= a;
            opb <= b_eff;
        end else if (state == RUN) begin
            opa <= opa >> CHUNK;
            opb <= opb >> CHUNK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt   <= '0;
                carry <= cin_eff;
            end else if (state == RUN) begin
                sum[int'(cnt) * CHUNK +: CHUNK] <= slice_sum;
                carry <= slice_carry;
                if (last_slice) begin
                    cnt  <= '0;
                    cout <= slice_carry;
                    ovf  <= msb_carry_in ^ slice_carry;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
